// File: rtl/stream_demux.sv
// Packet-aware 1:2 stream demux with one output register per port.
// Route is latched on a packet's first beat and held until its last beat.
module stream_demux #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic             ctrl,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] a_data,
  output logic             a_last,
  output logic [7:0]       a_pkts,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [WIDTH-1:0] b_data,
  output logic             b_last,
  output logic [7:0]       b_pkts
);

  // IDLE: between packets, route follows ctrl | LOCK_A/LOCK_B: packet open to a/b
  typedef enum logic [1:0] {IDLE, LOCK_A, LOCK_B} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_a_valid;
  logic             r_a_last;
  logic [WIDTH-1:0] r_a_data;
  logic [7:0]       r_a_pkts;
  logic             r_b_valid;
  logic             r_b_last;
  logic [WIDTH-1:0] r_b_data;
  logic [7:0]       r_b_pkts;
  logic             w_tgt_a;
  logic             w_a_free;
  logic             w_b_free;
  logic             w_accept;
  logic             w_load_a;
  logic             w_load_b;

  assign w_tgt_a  = (r_state == IDLE) ? ctrl : (r_state == LOCK_A);
  assign w_a_free = !r_a_valid || a_ready;
  assign w_b_free = !r_b_valid || b_ready;
  // Gated by rst_n so the upstream sees no ready while the block is held in reset.
  assign in_ready = rst_n && (w_tgt_a ? w_a_free : w_b_free);
  assign w_accept = in_valid && in_ready;
  assign w_load_a = w_accept && w_tgt_a;
  assign w_load_b = w_accept && !w_tgt_a;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept && !in_last) begin
          w_state_nxt = ctrl ? LOCK_A : LOCK_B;
        end
      end
      LOCK_A, LOCK_B: begin
        if (w_accept && in_last) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_valid <= 1'b0;
      r_a_last  <= 1'b0;
      r_a_data  <= '0;
      r_a_pkts  <= 8'd0;
    end else begin
      if (w_load_a) begin
        r_a_valid <= 1'b1;
        r_a_last  <= in_last;
        r_a_data  <= in_data;
        if (in_last) begin
          r_a_pkts <= r_a_pkts + 8'd1;
        end
      end else if (a_ready) begin
        r_a_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_b_valid <= 1'b0;
      r_b_last  <= 1'b0;
      r_b_data  <= '0;
      r_b_pkts  <= 8'd0;
    end else begin
      if (w_load_b) begin
        r_b_valid <= 1'b1;
        r_b_last  <= in_last;
        r_b_data  <= in_data;
        if (in_last) begin
          r_b_pkts <= r_b_pkts + 8'd1;
        end
      end else if (b_ready) begin
        r_b_valid <= 1'b0;
      end
    end
  end

  assign a_valid = r_a_valid;
  assign a_last  = r_a_last;
  assign a_data  = r_a_data;
  assign a_pkts  = r_a_pkts;
  assign b_valid = r_b_valid;
  assign b_last  = r_b_last;
  assign b_data  = r_b_data;
  assign b_pkts  = r_b_pkts;

endmodule

// File: tb/tb_stream_demux.sv
// Directed bench for stream_demux: routing, lock, backpressure, independence,
// counter wrap and asynchronous reset, against hand-computed values.
module tb_stream_demux;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_last;
  logic       ctrl;
  logic       a_valid;
  logic       a_ready;
  logic [7:0] a_data;
  logic       a_last;
  logic [7:0] a_pkts;
  logic       b_valid;
  logic       b_ready;
  logic [7:0] b_data;
  logic       b_last;
  logic [7:0] b_pkts;

  int n_checks;
  int n_errors;

  stream_demux #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .ctrl     (ctrl),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .a_data   (a_data),
    .a_last   (a_last),
    .a_pkts   (a_pkts),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .b_data   (b_data),
    .b_last   (b_last),
    .b_pkts   (b_pkts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic c, input logic [7:0] d, input logic l);
    in_valid = v;
    ctrl     = c;
    in_data  = d;
    in_last  = l;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    a_ready  = 1'b0;
    b_ready  = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    #2;
    check("rst_a_valid", a_valid, 1'b0);
    check("rst_b_valid", b_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_a_pkts", a_pkts, 8'd0);
    check("rst_b_pkts", b_pkts, 8'd0);
    tick();
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", in_ready, 1'b1);

    // Single-beat routing to a
    a_ready = 1'b1;
    b_ready = 1'b1;
    drive(1'b1, 1'b1, 8'h5A, 1'b1);
    tick();
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    check("single_a_valid", a_valid, 1'b1);
    check("single_a_data", a_data, 8'h5A);
    check("single_a_last", a_last, 1'b1);
    check("single_b_valid", b_valid, 1'b0);
    check("single_a_pkts", a_pkts, 8'd1);
    tick();
    check("single_a_drain", a_valid, 1'b0);

    // Lock: 3-beat packet to b while ctrl toggles
    drive(1'b1, 1'b0, 8'h01, 1'b0);
    tick();
    check("lock_b1_valid", b_valid, 1'b1);
    check("lock_b1_data", b_data, 8'h01);
    check("lock_b1_last", b_last, 1'b0);
    drive(1'b1, 1'b1, 8'h02, 1'b0);
    tick();
    check("lock_b2_data", b_data, 8'h02);
    check("lock_b2_last", b_last, 1'b0);
    check("lock_b2_a_valid", a_valid, 1'b0);
    drive(1'b1, 1'b0, 8'h03, 1'b1);
    tick();
    check("lock_b3_data", b_data, 8'h03);
    check("lock_b3_last", b_last, 1'b1);
    check("lock_b_pkts", b_pkts, 8'd1);
    check("lock_a_valid", a_valid, 1'b0);
    check("lock_a_pkts", a_pkts, 8'd1);
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    tick();
    check("lock_b_drain", b_valid, 1'b0);

    // Backpressure on a with a 2-beat packet
    a_ready = 1'b0;
    drive(1'b1, 1'b1, 8'h11, 1'b0);
    tick();
    check("bp_a1_valid", a_valid, 1'b1);
    check("bp_a1_data", a_data, 8'h11);
    drive(1'b1, 1'b0, 8'h12, 1'b1);
    #1;
    check("bp_in_ready_low", in_ready, 1'b0);
    tick();
    check("bp_hold_data", a_data, 8'h11);
    check("bp_hold_last", a_last, 1'b0);
    check("bp_hold_valid", a_valid, 1'b1);
    check("bp_b_valid", b_valid, 1'b0);
    tick();
    check("bp_hold2_data", a_data, 8'h11);
    a_ready = 1'b1;
    #1;
    check("bp_passthru_ready", in_ready, 1'b1);
    tick();
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    check("bp_a2_data", a_data, 8'h12);
    check("bp_a2_last", a_last, 1'b1);
    check("bp_a_pkts", a_pkts, 8'd2);
    tick();
    check("bp_a_drain", a_valid, 1'b0);

    // Independence: b stalled with a beat while a streams
    b_ready = 1'b0;
    drive(1'b1, 1'b0, 8'h21, 1'b1);
    tick();
    check("ind_b_valid", b_valid, 1'b1);
    check("ind_b_data", b_data, 8'h21);
    drive(1'b1, 1'b1, 8'h31, 1'b0);
    #1;
    check("ind_ready1", in_ready, 1'b1);
    tick();
    check("ind_a1_data", a_data, 8'h31);
    drive(1'b1, 1'b0, 8'h32, 1'b0);
    #1;
    check("ind_ready2", in_ready, 1'b1);
    tick();
    check("ind_a2_data", a_data, 8'h32);
    check("ind_b_hold", b_data, 8'h21);
    drive(1'b1, 1'b0, 8'h33, 1'b1);
    #1;
    check("ind_ready3", in_ready, 1'b1);
    tick();
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    check("ind_a3_data", a_data, 8'h33);
    check("ind_a3_last", a_last, 1'b1);
    check("ind_a_pkts", a_pkts, 8'd3);
    check("ind_b_valid_hold", b_valid, 1'b1);
    check("ind_b_pkts", b_pkts, 8'd2);
    b_ready = 1'b1;
    tick();
    check("ind_b_drain", b_valid, 1'b0);
    check("ind_a_drain", a_valid, 1'b0);

    // Reset mid-packet during beat 2 of a 4-beat packet to b
    drive(1'b1, 1'b0, 8'h41, 1'b0);
    tick();
    check("rstm_b1_data", b_data, 8'h41);
    drive(1'b1, 1'b0, 8'h42, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstm_b_valid", b_valid, 1'b0);
    check("rstm_b_data", b_data, 8'h00);
    check("rstm_a_pkts", a_pkts, 8'd0);
    check("rstm_b_pkts", b_pkts, 8'd0);
    check("rstm_in_ready", in_ready, 1'b0);
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    tick();
    rst_n = 1'b1;
    drive(1'b1, 1'b1, 8'h51, 1'b1);
    #1;
    check("rstm_ready_after", in_ready, 1'b1);
    tick();
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    check("rstm_a_valid", a_valid, 1'b1);
    check("rstm_a_data", a_data, 8'h51);
    check("rstm_b_valid_after", b_valid, 1'b0);
    check("rstm_a_pkts_after", a_pkts, 8'd1);
    tick();

    // Wrap: 256 single-beat packets to a from a clean reset
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    drive(1'b1, 1'b1, 8'hC3, 1'b1);
    repeat (255) tick();
    check("wrap_a_pkts_ff", a_pkts, 8'hFF);
    tick();
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    check("wrap_a_pkts_00", a_pkts, 8'h00);
    check("wrap_b_pkts", b_pkts, 8'h00);
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/stream_demux.md
STREAM_DEMUX -- requirements
Module: stream_demux

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width of every data port.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  upstream beat valid.
REQ-005 SHALL have port in_ready  output  1  beat accepted when in_valid and in_ready are both high at a rising clk edge.
REQ-006 SHALL have port in_data  input  WIDTH  upstream beat data.
REQ-007 SHALL have port in_last  input  1  final beat of packet.
REQ-008 SHALL have port ctrl  input  1  route select; 1 selects port a, 0 selects port b.
REQ-009 SHALL have ports a_valid/b_valid  output  1  output beat valid.
REQ-010 SHALL have ports a_ready/b_ready  input  1  downstream ready.
REQ-011 SHALL have ports a_data/b_data  output  WIDTH  output beat data.
REQ-012 SHALL have ports a_last/b_last  output  1  output last flag.
REQ-013 SHALL have ports a_pkts/b_pkts  output  8  count of packets whose last beat was accepted for that port.

Function
REQ-014 SHALL implement FSM states IDLE, LOCK_A, LOCK_B.
REQ-015 In IDLE, target port SHALL be ctrl as sampled at the edge where the first beat of a packet is accepted.
REQ-016 On acceptance in IDLE with in_last=0, FSM SHALL go to LOCK_A (ctrl=1) or LOCK_B (ctrl=0).
REQ-017 On acceptance in IDLE with in_last=1 (single-beat packet), FSM SHALL stay in IDLE.
REQ-018 In LOCK_A/LOCK_B, target SHALL be fixed; ctrl changes SHALL be ignored until the packet ends.
REQ-019 Acceptance of a beat with in_last=1 in LOCK_x SHALL return FSM to IDLE on the same edge.
REQ-020 Each output port SHALL have one output register: valid, data, last.
REQ-021 in_ready SHALL be high iff the target port register is empty, or target x_valid and x_ready are both high in the current cycle (pass-through refill).
REQ-022 An accepted beat SHALL appear on the target port's x_valid/x_data/x_last on the next cycle (latency 1).
REQ-023 x_valid SHALL clear after an edge with x_valid and x_ready high and no new beat loaded.
REQ-024 x_valid, x_data and x_last SHALL hold stable while x_valid=1 and x_ready=0.
REQ-025 The non-target port register SHALL drain independently and never receive data.
REQ-026 in_ready SHALL not depend on the non-target port's ready.
REQ-027 x_pkts SHALL increment by 1 on the edge a last beat for port x is accepted, wrapping 255 -> 0.
REQ-028 With in_valid=0, FSM and counters SHALL hold.
REQ-029 No beat SHALL be duplicated, dropped, or reordered within a port outside reset.

Reset
REQ-030 While rst_n=0, state SHALL be IDLE; a_valid, b_valid, a_last, b_last, a_data, b_data, a_pkts, b_pkts SHALL be 0; in_ready SHALL be 0.
REQ-031 Reset assertion mid-packet SHALL take effect immediately without a clock and discard partial packets and register contents.
REQ-032 After rst_n rises, in_ready SHALL be high in the first cycle, since both registers are empty.

Verification
REQ-033 Bench SHALL cover single-beat routing: ctrl=1, in_data=0x5A, in_last=1, a_ready=1 -> next cycle a_valid=1, a_data=0x5A, a_last=1, b_valid=0, a_pkts=1.
REQ-034 Bench SHALL cover lock: a 3-beat packet 0x01,0x02,0x03 starts with ctrl=0 and ctrl toggles every cycle -> all three beats appear on b in order, b_last only on 0x03, and b_pkts=1.
REQ-035 Bench SHALL cover backpressure: a_ready=0 with a 2-beat packet -> the first beat is held stable on a, in_ready=0 for the second beat, and a_ready=1 releases the beats one per cycle.
REQ-036 Bench SHALL cover independence: b holds a beat with b_ready=0 while a packet with ctrl=1 streams to a at full rate with a_ready=1, and in_ready stays 1.
REQ-037 Bench SHALL cover wrap: 256 single-beat packets to a -> a_pkts returns to 0x00.
REQ-038 Bench SHALL cover reset: rst_n pulsed low during beat 2 of a 4-beat packet -> all outputs 0 asynchronously, and the next packet with ctrl=1 routes to a from IDLE.
